// File: rtl/fpu_sched_pkg.sv
// rtl/fpu_sched_pkg.sv - shared opcodes, FSM states, flag indices and latency lookup for the FPU scheduler
package fpu_sched_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  localparam int FLAG_INVALID = 0;
  localparam int FLAG_DIV0    = 1;
  localparam int FLAG_INF     = 2;

  localparam logic [63:0] FP_ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [62:0] FP_INF_MAG  = 63'h7FF0_0000_0000_0000;

  // Issue-to-result latency of an opcode; the latencies are block parameters.
  function automatic int lat_of(input logic [1:0] op, input int add_lat,
                                input int mul_lat, input int div_lat);
    case (op)
      OP_MUL:  lat_of = mul_lat;
      OP_DIV:  lat_of = div_lat;
      default: lat_of = add_lat;
    endcase
  endfunction

endpackage

// File: rtl/fpu_dp.sv
// rtl/fpu_dp.sv - combinational double-precision add/sub/mul/div datapath (truncating, denormals flushed)
module fpu_dp
  import fpu_sched_pkg::*;
(
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [1:0]  op_i,
  output logic [63:0] result_o
);

  function automatic logic [5:0] lzc57(input logic [56:0] v);
    logic found;
    found = 1'b0;
    lzc57 = 6'd0;
    for (int i = 56; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      lzc57 = lzc57 + 6'd1;
      end
    end
  endfunction

  // Saturate to signed infinity on overflow and to signed zero on underflow.
  function automatic logic [63:0] pack(input logic s, input logic signed [13:0] ex,
                                       input logic [51:0] fr);
    if (ex >= 14'sd2047)  pack = {s, FP_INF_MAG};
    else if (ex <= 14'sd0) pack = {s, 63'h0};
    else                   pack = {s, ex[10:0], fr};
  endfunction

  logic sa, sb, sbe, sx, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, big_s, small_s;
  logic [10:0]  ea, eb, big_e, small_e, d;
  logic [52:0]  ma, mb, big_m, small_m;
  logic [56:0]  sum, sum_n;
  logic [5:0]   lz;
  logic [105:0] prod;
  logic [53:0]  prod_hi;
  logic [106:0] quo;
  logic [54:0]  quo_lo;
  logic signed [13:0] ex;

  // Special operands first, then the magnitude path of the selected operation.
  always_comb begin
    sa = a_i[63]; ea = a_i[62:52]; ma = {1'b1, a_i[51:0]};
    sb = b_i[63]; eb = b_i[62:52]; mb = {1'b1, b_i[51:0]};
    a_nan  = (ea == 11'h7FF) && (a_i[51:0] != 52'h0);
    b_nan  = (eb == 11'h7FF) && (b_i[51:0] != 52'h0);
    a_inf  = (ea == 11'h7FF) && (a_i[51:0] == 52'h0);
    b_inf  = (eb == 11'h7FF) && (b_i[51:0] == 52'h0);
    a_zero = (ea == 11'h0);
    b_zero = (eb == 11'h0);
    sbe = sb ^ op_i[0];
    sx  = sa ^ sb;
    swap = b_i[62:0] > a_i[62:0];
    big_s   = swap ? sbe : sa;  small_s = swap ? sa : sbe;
    big_e   = swap ? eb : ea;   small_e = swap ? ea : eb;
    big_m   = swap ? mb : ma;   small_m = swap ? ma : mb;
    d = big_e - small_e;
    if (big_s == small_s) sum = {1'b0, big_m, 3'b0} + ({1'b0, small_m, 3'b0} >> d);
    else                  sum = {1'b0, big_m, 3'b0} - ({1'b0, small_m, 3'b0} >> d);
    lz    = lzc57(sum);
    sum_n = sum << lz;
    prod    = 106'(ma) * 106'(mb);
    prod_hi = 54'(prod >> 52);
    quo     = {ma, 54'h0} / 107'(mb);
    quo_lo  = 55'(quo);
    ex = 14'sd0;
    result_o = 64'h0;
    if (a_nan || b_nan) begin
      result_o = FP_ALL_ONES;
    end else begin
      case (op_i)
        OP_MUL: begin
          if ((a_inf && b_zero) || (a_zero && b_inf)) result_o = FP_ALL_ONES;
          else if (a_inf || b_inf)                    result_o = {sx, FP_INF_MAG};
          else if (a_zero || b_zero)                  result_o = {sx, 63'h0};
          else begin
            ex = $signed({3'b0, ea}) + $signed({3'b0, eb}) - 14'sd1023;
            if (prod_hi[53]) result_o = pack(sx, ex + 14'sd1, prod_hi[52:1]);
            else             result_o = pack(sx, ex, prod_hi[51:0]);
          end
        end
        OP_DIV: begin
          if ((a_zero && b_zero) || (a_inf && b_inf)) result_o = FP_ALL_ONES;
          else if (b_zero)                            result_o = {1'b0, FP_INF_MAG};
          else if (a_inf)                             result_o = {sx, FP_INF_MAG};
          else if (b_inf || a_zero)                   result_o = {sx, 63'h0};
          else begin
            ex = $signed({3'b0, ea}) - $signed({3'b0, eb}) + 14'sd1023;
            if (quo_lo[54]) result_o = pack(sx, ex, quo_lo[53:2]);
            else            result_o = pack(sx, ex - 14'sd1, quo_lo[52:1]);
          end
        end
        default: begin
          if (a_inf && b_inf)        result_o = (sa == sbe) ? {sa, FP_INF_MAG} : FP_ALL_ONES;
          else if (a_inf)            result_o = {sa, FP_INF_MAG};
          else if (b_inf)            result_o = {sbe, FP_INF_MAG};
          else if (a_zero && b_zero) result_o = {sa & sbe, 63'h0};
          else if (a_zero)           result_o = {sbe, b_i[62:0]};
          else if (b_zero)           result_o = a_i;
          else if (sum == 57'h0)     result_o = 64'h0;
          else begin
            ex = $signed({3'b0, big_e}) + 14'sd1 - $signed({8'b0, lz});
            result_o = pack(big_s, ex, 52'(sum_n >> 4));
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fpu_rr_arbiter.sv
// rtl/fpu_rr_arbiter.sv - combinational round-robin arbiter, search starts at the supplied pointer
module fpu_rr_arbiter
  import fpu_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            gnt_vld_o
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                pos;

  // Rotate the request vector so the pointer sits at bit 0, take the lowest set bit, map back.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    pos       = 0;
    dbl       = {req_i, req_i} >> ptr_i;
    rot       = NREQ'(dbl);
    for (int k = 0; k < NREQ; k++) begin
      if (en_i && !gnt_vld_o && rot[k]) begin
        gnt_vld_o = 1'b1;
        pos       = int'(ptr_i) + k;
        if (pos >= NREQ) pos = pos - NREQ;
        gnt_idx_o = IDW'(pos);
      end
    end
    if (gnt_vld_o) gnt_o = NREQ'(1) << gnt_idx_o;
  end

endmodule

// File: rtl/fpu_op_scheduler.sv
// rtl/fpu_op_scheduler.sv - round-robin shared FPU front end with per-op latency; FPU_SCHED_FLAGS_EN adds rsp_flags
module fpu_op_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*64-1:0] req_a,
  input  logic [NREQ*64-1:0] req_b,
  input  logic [NREQ*2-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_result,
  output logic [IDW-1:0]    rsp_id,
`ifdef FPU_SCHED_FLAGS_EN
  output logic [2:0]        rsp_flags,
`endif
  output logic              busy
);

  localparam int CW = 16;

  sched_state_e   state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, rsp_id_q, rsp_id_d, gnt_idx;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [63:0]    a_q, a_d, b_q, b_d, rsp_result_q, rsp_result_d, fpu_res;
  logic [1:0]     op_q, op_d;
  logic           rsp_valid_q, rsp_valid_d, gnt_vld;
  logic [NREQ-1:0] gnt;

  // Grants are only offered while idle and out of reset.
  fpu_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .en_i     ((state_q == IDLE) && rst_n),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx),
    .gnt_vld_o(gnt_vld)
  );

  // The FPU sees only the latched operands, so requester inputs are free to change during EXEC.
  fpu_dp u_fpu (.a_i(a_q), .b_i(b_q), .op_i(op_q), .result_o(fpu_res));

  assign req_ready  = gnt;
  assign busy       = (state_q != IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;

`ifdef FPU_SCHED_FLAGS_EN
  logic [2:0] flags_q, flags_d, flags_now;

  // Operand classification of the latched op, captured alongside the result.
  always_comb begin
    flags_now = 3'b000;
    flags_now[FLAG_INVALID] = ((a_q[62:52] == 11'h7FF) && (a_q[51:0] != 52'h0)) ||
                              ((b_q[62:52] == 11'h7FF) && (b_q[51:0] != 52'h0));
    flags_now[FLAG_DIV0]    = (op_q == OP_DIV) && (b_q[62:0] == 63'h0);
    flags_now[FLAG_INF]     = ((a_q[62:52] == 11'h7FF) && (a_q[51:0] == 52'h0)) ||
                              ((b_q[62:52] == 11'h7FF) && (b_q[51:0] == 52'h0));
  end

  assign rsp_flags = flags_q;
`endif

  // Next-state: accept in IDLE, count down in EXEC, hold the response in DONE until taken.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
`ifdef FPU_SCHED_FLAGS_EN
    flags_d      = flags_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          a_d   = req_a[int'(gnt_idx)*64 +: 64];
          b_d   = req_b[int'(gnt_idx)*64 +: 64];
          op_d  = req_op[int'(gnt_idx)*2 +: 2];
          id_d  = gnt_idx;
          cnt_d = CW'(lat_of(req_op[int'(gnt_idx)*2 +: 2], ADD_LAT, MUL_LAT, DIV_LAT) - 1);
          ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rsp_result_d = fpu_res;
          rsp_id_d     = id_q;
          rsp_valid_d  = 1'b1;
`ifdef FPU_SCHED_FLAGS_EN
          flags_d      = flags_now;
`endif
          state_d      = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any op in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= '0;
`ifdef FPU_SCHED_FLAGS_EN
      flags_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
`ifdef FPU_SCHED_FLAGS_EN
      flags_q      <= flags_d;
`endif
    end
  end

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// tb/tb_fpu_op_scheduler.sv - self-checking bench for fpu_op_scheduler with a timeline reference model
module tb_fpu_op_scheduler;
  import fpu_sched_pkg::*;

  localparam int NREQ = 2, ADD_LAT = 1, MUL_LAT = 3, DIV_LAT = 8, IDW = 1;

  logic clk, rst_n, rsp_valid, rsp_ready, busy;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*64-1:0] req_a, req_b;
  logic [NREQ*2-1:0] req_op;
  logic [63:0] rsp_result;
  logic [IDW-1:0] rsp_id;
`ifdef FPU_SCHED_FLAGS_EN
  logic [2:0] rsp_flags;
`endif

  fpu_op_scheduler #(.NREQ(NREQ), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_id(rsp_id),
`ifdef FPU_SCHED_FLAGS_EN
    .rsp_flags(rsp_flags),
`endif
    .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        drv_valid [NREQ];
  logic [63:0] drv_a [NREQ];
  logic [63:0] drv_b [NREQ];
  logic [1:0]  drv_op [NREQ];

  always_comb begin
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    for (int r = 0; r < NREQ; r++) begin
      req_valid[r]       = drv_valid[r];
      req_a[64*r +: 64]  = drv_a[r];
      req_b[64*r +: 64]  = drv_b[r];
      req_op[2*r +: 2]   = drv_op[r];
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // IEEE reference via real arithmetic, plus the datapath's special encodings.
  function automatic logic [63:0] ref_fpu(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    real ra, rb, r;
    if ((a[62:52] == 11'h7FF && a[51:0] != 0) || (b[62:52] == 11'h7FF && b[51:0] != 0)) return '1;
    if (op == OP_DIV && b[62:0] == 0) return (a[62:0] == 0) ? '1 : 64'h7FF0_0000_0000_0000;
    ra = $bitstoreal(a); rb = $bitstoreal(b);
    case (op)
      OP_ADD:  r = ra + rb;
      OP_SUB:  r = ra - rb;
      OP_MUL:  r = ra * rb;
      default: r = ra / rb;
    endcase
    return $realtobits(r);
  endfunction

  function automatic logic [2:0] ref_flags(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    logic [2:0] f;
    f[0] = (a[62:52] == 11'h7FF && a[51:0] != 0) || (b[62:52] == 11'h7FF && b[51:0] != 0);
    f[1] = (op == OP_DIV) && (b[62:0] == 0);
    f[2] = (a[62:52] == 11'h7FF && a[51:0] == 0) || (b[62:52] == 11'h7FF && b[51:0] == 0);
    return f;
  endfunction

  function automatic int op_lat(input logic [1:0] op);
    return (op == OP_MUL) ? MUL_LAT : (op == OP_DIV) ? DIV_LAT : ADD_LAT;
  endfunction

  // Model: a single op in flight, response due lat cycles after its accept, freed by the handshake.
  bit          m_known = 0, m_busy = 0, m_zero = 0;
  int          m_ptr = 0, m_acc = 0, m_lat = 0, ncyc = 0;
  logic [63:0] m_res = '0;
  int          m_id = 0;
  logic [2:0]  m_flags = '0;
  int          grant_log[$];
  logic [63:0] rlog_res[$];
  int          rlog_id[$];

  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    int win, j;
    logic ev;
    er = '0; win = -1; j = 0;
    if (!m_busy && rst_n)
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (win < 0 && drv_valid[j]) win = j;
      end
    if (win >= 0) er[win] = 1'b1;
    ev = m_busy && (ncyc >= m_acc + 1 + m_lat);
    if (m_known) begin
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("rsp_valid", 64'(rsp_valid), 64'(ev));
      if (ev) begin
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_id", 64'(rsp_id), 64'(m_id));
`ifdef FPU_SCHED_FLAGS_EN
        chk("rsp_flags", 64'(rsp_flags), 64'(m_flags));
`endif
      end else if (m_zero) begin
        chk("rsp_result_rst", rsp_result, 64'h0);
        chk("rsp_id_rst", 64'(rsp_id), 64'h0);
      end
    end
    if (!rst_n) begin
      m_known = 1; m_busy = 0; m_ptr = 0; m_zero = 1;
    end else if (!m_busy) begin
      if (win >= 0) begin
        m_busy = 1; m_acc = ncyc; m_lat = op_lat(drv_op[win]); m_id = win;
        m_res = ref_fpu(drv_a[win], drv_b[win], drv_op[win]);
        m_flags = ref_flags(drv_a[win], drv_b[win], drv_op[win]);
        m_ptr = (win + 1) % NREQ;
        grant_log.push_back(win);
      end
    end else if (ev) begin
      m_zero = 0;
      if (rsp_ready) begin
        m_busy = 0;
        rlog_res.push_back(m_res);
        rlog_id.push_back(m_id);
      end
    end
    ncyc++;
  end

  function automatic logic [63:0] fp(input int k);
    return $realtobits(real'(k));
  endfunction

  task automatic gen_op(output logic [1:0] op, output logic [63:0] a, output logic [63:0] b);
    int ka, kb, q;
    op = 2'($urandom_range(0, 3));
    if (op == OP_DIV) begin
      kb = int'($urandom_range(1, 12));
      if ($urandom_range(0, 1) == 1) kb = -kb;
      q  = int'($urandom_range(0, 24)) - 12;
      ka = kb * q;
    end else begin
      ka = int'($urandom_range(0, 128)) - 64;
      kb = int'($urandom_range(0, 128)) - 64;
    end
    a = fp(ka); b = fp(kb);
  endtask

  task automatic drive(input int r, input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    drv_valid[r] = 1'b1; drv_a[r] = a; drv_b[r] = b; drv_op[r] = op;
  endtask

  // Returns at posedge+1 of the accepting edge with the requester's valid dropped.
  task automatic wait_accept(input int r);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        @(posedge clk); #1;
        drv_valid[r] = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) chk("idle_timeout", 64'(busy), 64'(0));
  endtask

  initial begin
    int n, bg, br;
    for (int r = 0; r < NREQ; r++) begin drv_valid[r] = 0; drv_a[r] = '0; drv_b[r] = '0; drv_op[r] = '0; end
    rst_n = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_result", rsp_result, 64'h0);
    rst_n = 1'b1;

    // Add on requester 0, latency 1.
    @(posedge clk); #1;
    drive(0, 64'h3FF0000000000000, 64'h4000000000000000, OP_ADD);
    wait_accept(0); wait_rsp(n);
    chk("add_lat", 64'(n), 64'(ADD_LAT));
    chk("add_result", rsp_result, 64'h4008000000000000);
    chk("add_id", 64'(rsp_id), 64'(0));
    wait_idle();

    // Mul on requester 1, latency 3.
    drive(1, 64'h4008000000000000, 64'h4000000000000000, OP_MUL);
    wait_accept(1); wait_rsp(n);
    chk("mul_lat", 64'(n), 64'(MUL_LAT));
    chk("mul_result", rsp_result, 64'h4018000000000000);
    chk("mul_id", 64'(rsp_id), 64'(1));
    wait_idle();

    // Fairness with both requesters held valid.
    bg = grant_log.size(); br = rlog_res.size();
    drive(0, 64'h4018000000000000, 64'h4000000000000000, OP_DIV);
    drive(1, 64'h3FF0000000000000, 64'h4000000000000000, OP_SUB);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (grant_log.size() >= bg + 4) break;
    end
    drv_valid[0] = 0; drv_valid[1] = 0;
    wait_idle();
    chk("fair_grants", 64'(grant_log.size() - bg), 64'(4));
    chk("fair_rsps", 64'(rlog_res.size() - br), 64'(4));
    if (grant_log.size() >= bg + 4 && rlog_res.size() >= br + 4)
      for (int i = 0; i < 4; i++) begin
        chk("fair_order", 64'(grant_log[bg+i]), 64'(i % 2));
        chk("fair_rsp_id", 64'(rlog_id[br+i]), 64'(i % 2));
        chk("fair_rsp_res", rlog_res[br+i], (i % 2 == 0) ? 64'h4008000000000000 : 64'hBFF0000000000000);
      end

    // Backpressure: response held for 5 cycles with a competing request pending.
    rsp_ready = 1'b0;
    drive(0, 64'h3FF0000000000000, 64'h4000000000000000, OP_ADD);
    drive(1, 64'h4008000000000000, 64'h4000000000000000, OP_MUL);
    wait_accept(0); wait_rsp(n);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_result", rsp_result, 64'h4008000000000000);
      chk("bp_id", 64'(rsp_id), 64'(0));
      chk("bp_req_ready", 64'(req_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_after_hs_valid", 64'(rsp_valid), 64'(0));
    chk("bp_after_hs_ready", 64'(req_ready), 64'(2'b10));
    @(posedge clk); #1;
    drv_valid[1] = 0;
    chk("bp_next_busy", 64'(busy), 64'(1));
    wait_idle();

    // Reset during a DIV: no response, pointer back to 0.
    br = rlog_res.size();
    drive(0, 64'h4018000000000000, 64'h4000000000000000, OP_DIV);
    wait_accept(0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", 64'(rsp_valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    drive(0, 64'h3FF0000000000000, 64'h4000000000000000, OP_ADD);
    drive(1, 64'h4008000000000000, 64'h4000000000000000, OP_MUL);
    #1;
    chk("midrst_ptr", 64'(req_ready), 64'(2'b01));
    wait_accept(0);
    drv_valid[1] = 0;
    wait_idle();
    chk("midrst_rsp_count", 64'(rlog_res.size() - br), 64'(1));
    if (rlog_res.size() > br) chk("midrst_rsp_res", rlog_res[br], 64'h4008000000000000);

    // Special values: divide by zero and NaN operand.
    drive(0, 64'h3FF0000000000000, 64'h0, OP_DIV);
    wait_accept(0); wait_rsp(n);
    chk("div0_result", rsp_result, 64'h7FF0000000000000);
`ifdef FPU_SCHED_FLAGS_EN
    chk("div0_flags", 64'(rsp_flags), 64'(3'b010));
`endif
    wait_idle();
    drive(1, 64'hFFF8000000000000, 64'h3FF0000000000000, OP_ADD);
    wait_accept(1); wait_rsp(n);
    chk("nan_result", rsp_result, 64'hFFFFFFFFFFFFFFFF);
`ifdef FPU_SCHED_FLAGS_EN
    chk("nan_flag0", 64'(rsp_flags[0]), 64'(1));
`endif
    wait_idle();

    // Random traffic, random backpressure, one reset in the middle.
    for (int c = 0; c < 600; c++) begin
      logic [1:0] op;
      logic [63:0] a, b;
      @(posedge clk); #1;
      rst_n = (c != 300);
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(0, 3) == 0) drv_valid[r] = ~drv_valid[r];
        gen_op(op, a, b);
        drv_a[r] = a; drv_b[r] = b; drv_op[r] = op;
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk); #1;
    for (int r = 0; r < NREQ; r++) drv_valid[r] = 0;
    rsp_ready = 1'b1;
    wait_idle();
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
